pcie_dllp_tx_scheduler: RTL and testbench

Sequences every DLLP the data link layer transmits and shares the single DLLP transmit path between three requesters: the flow-control initialization state machine, the Ack/Nak generator, and the UpdateFC generator. It builds 32-bit DLLP bodies from `pcie_datalink_pkg` encodings (`dllp_fc_t`, `dllp_ack_nack_t`, `flow_control_state_e`) and presents them on an AXI-Stream-style valid/ready output. The downstream stage appends the 16-bit CRC.

---
 rtl/pcie_dllp_tx_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_pcie_dllp_tx_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_dllp_tx_scheduler.sv
// DLLP transmit scheduler: InitFC1/InitFC2 sequencing, then Nak > Ack > round-robin UpdateFC.
// Optional periodic UpdateFC timer is enabled by defining DLLP_TX_UPDFC_TIMER_EN.
package pcie_datalink_pkg;
    typedef enum logic [1:0] {
        DL_DOWN   = 2'd0,
        DL_UP     = 2'd1,
        DL_ACTIVE = 2'd2
    } pcie_dl_status_e;

    typedef enum logic [3:0] {
        INIT_FCDLE       = 4'd0,
        INIT_FC1_P       = 4'd1,
        INIT_FC1_NP      = 4'd2,
        INIT_FC1_CPL     = 4'd3,
        CHECK_FC1_VALS   = 4'd4,
        INIT_FC2_P       = 4'd5,
        INIT_FC2_NP      = 4'd6,
        INIT_FC2_CPL     = 4'd7,
        CHECK_FC2_VALS   = 4'd8,
        INIT_FC_COMPLETE = 4'd9
    } flow_control_state_e;

    typedef enum logic [7:0] {
        DLLP_ACK        = 8'h00,
        DLLP_NAK        = 8'h10,
        DLLP_INITFC1_P  = 8'h40,
        DLLP_INITFC1_NP = 8'h50,
        DLLP_INITFC1_CPL= 8'h60,
        DLLP_UPDFC_P    = 8'h80,
        DLLP_UPDFC_NP   = 8'h90,
        DLLP_UPDFC_CPL  = 8'hA0,
        DLLP_INITFC2_P  = 8'hC0,
        DLLP_INITFC2_NP = 8'hD0,
        DLLP_INITFC2_CPL= 8'hE0
    } dllp_type_t;

    typedef struct packed {
        logic [7:0] data_lo;
        logic [1:0] hdr_lo;
        logic [1:0] rsvd1;
        logic [3:0] data_hi;
        logic [1:0] rsvd0;
        logic [5:0] hdr_hi;
        logic [7:0] dtype;
    } dllp_fc_t;

    typedef struct packed {
        logic [7:0] seq_lo;
        logic [3:0] rsvd1;
        logic [3:0] seq_hi;
        logic [7:0] rsvd0;
        logic [7:0] dtype;
    } dllp_ack_nack_t;
endpackage

module pcie_dllp_tx_scheduler
    import pcie_datalink_pkg::*;
#(
    parameter logic [2:0]  VC_ID        = 3'd0,
    parameter logic [7:0]  FC_P_HDR     = 8'h01,
    parameter logic [7:0]  FC_NP_HDR    = 8'h01,
    parameter logic [7:0]  FC_CPL_HDR   = 8'h01,
    parameter logic [11:0] FC_P_DATA    = 12'h040,
    parameter logic [11:0] FC_NP_DATA   = 12'h010,
    parameter logic [11:0] FC_CPL_DATA  = 12'h040,
    parameter int          UPDFC_PERIOD = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  dl_status_i,
    input  logic        fc1_rx_i,
    input  logic        fc2_rx_i,
    input  logic        ack_req_i,
    input  logic        nak_req_i,
    input  logic [11:0] ack_seq_i,
    input  logic [2:0]  upd_req_i,
    input  logic [23:0] cred_hdr_i,
    input  logic [35:0] cred_data_i,
    output logic [31:0] m_dllp_tdata,
    output logic        m_dllp_tvalid,
    input  logic        m_dllp_tready,
    output logic [3:0]  fc_state_o,
    output logic        fc_init_done_o
);
    // Output handshake: a DLLP transfers on a clock edge where tvalid && tready are both high;
    // once tvalid is raised, tdata is held unchanged until that transfer happens.
    flow_control_state_e state;
    logic        fc1_seen, fc2_seen, ack_pend, nak_pend;
    logic [11:0] seq;
    logic [2:0]  upd_pend, upd_n, take_upd;
    logic [1:0]  rr_ptr, p1, p2, upd_sel;
    logic        load_en, load_item, take_ack, take_nak, ack_n, nak_n, tick;
    logic [11:0] seq_n, sel_data;
    logic [7:0]  sel_hdr, sel_type;
    logic [31:0] item;

    if (UPDFC_PERIOD < 1) begin : g_invalid_period
    end

    function automatic logic [1:0] nxt(input logic [1:0] t);
        return (t == 2'd2) ? 2'd0 : t + 2'd1;
    endfunction

    function automatic logic [31:0] fc_body(input logic [7:0] t, input logic [7:0] hdr,
                                            input logic [11:0] data);
        dllp_fc_t d;
        d.dtype   = t | {5'd0, VC_ID};
        d.hdr_hi  = hdr[7:2];
        d.rsvd0   = 2'b00;
        d.data_hi = data[11:8];
        d.rsvd1   = 2'b00;
        d.hdr_lo  = hdr[1:0];
        d.data_lo = data[7:0];
        return d;
    endfunction

    function automatic logic [31:0] seq_body(input logic [7:0] t, input logic [11:0] s);
        dllp_ack_nack_t d;
        d.dtype  = t;
        d.rsvd0  = 8'h00;
        d.seq_hi = s[11:8];
        d.rsvd1  = 4'h0;
        d.seq_lo = s[7:0];
        return d;
    endfunction

    assign load_en        = !m_dllp_tvalid || m_dllp_tready;
    assign fc_state_o     = state;

    // Round-robin search starts at rr_ptr, the type after the last one granted.
    always_comb begin
        p1 = nxt(rr_ptr);
        p2 = nxt(p1);
        if (upd_pend[rr_ptr])  upd_sel = rr_ptr;
        else if (upd_pend[p1]) upd_sel = p1;
        else                   upd_sel = p2;
        case (upd_sel)
            2'd0:    begin sel_type = DLLP_UPDFC_P;   sel_hdr = cred_hdr_i[7:0];   sel_data = cred_data_i[11:0];  end
            2'd1:    begin sel_type = DLLP_UPDFC_NP;  sel_hdr = cred_hdr_i[15:8];  sel_data = cred_data_i[23:12]; end
            default: begin sel_type = DLLP_UPDFC_CPL; sel_hdr = cred_hdr_i[23:16]; sel_data = cred_data_i[35:24]; end
        endcase
    end

    always_comb begin
        load_item = 1'b0;
        item      = '0;
        take_ack  = 1'b0;
        take_nak  = 1'b0;
        take_upd  = '0;
        case (state)
            INIT_FC1_P:   begin load_item = load_en; item = fc_body(DLLP_INITFC1_P,   FC_P_HDR,   FC_P_DATA);   end
            INIT_FC1_NP:  begin load_item = load_en; item = fc_body(DLLP_INITFC1_NP,  FC_NP_HDR,  FC_NP_DATA);  end
            INIT_FC1_CPL: begin load_item = load_en; item = fc_body(DLLP_INITFC1_CPL, FC_CPL_HDR, FC_CPL_DATA); end
            INIT_FC2_P:   begin load_item = load_en; item = fc_body(DLLP_INITFC2_P,   FC_P_HDR,   FC_P_DATA);   end
            INIT_FC2_NP:  begin load_item = load_en; item = fc_body(DLLP_INITFC2_NP,  FC_NP_HDR,  FC_NP_DATA);  end
            INIT_FC2_CPL: begin load_item = load_en; item = fc_body(DLLP_INITFC2_CPL, FC_CPL_HDR, FC_CPL_DATA); end
            INIT_FC_COMPLETE: begin
                if (nak_pend) begin
                    load_item = load_en; take_nak = load_en; item = seq_body(DLLP_NAK, seq);
                end else if (ack_pend) begin
                    load_item = load_en; take_ack = load_en; item = seq_body(DLLP_ACK, seq);
                end else if (|upd_pend) begin
                    load_item = load_en;
                    take_upd  = load_en ? 3'(3'b001 << upd_sel) : 3'b000;
                    item      = fc_body(sel_type, sel_hdr, sel_data);
                end
            end
            default: ;
        endcase
    end

    // A same-cycle request re-arms a pending bit that is being consumed.
    always_comb begin
        nak_n = nak_pend & ~take_nak;
        ack_n = ack_pend & ~take_ack;
        seq_n = seq;
        if (nak_req_i) begin
            nak_n = 1'b1;
            ack_n = 1'b0;
            seq_n = ack_seq_i;
        end else if (ack_req_i) begin
            seq_n = ack_seq_i;
            if (!nak_pend) ack_n = 1'b1;
        end
        upd_n = (upd_pend & ~take_upd) | upd_req_i | {3{tick}};
    end

`ifdef DLLP_TX_UPDFC_TIMER_EN
    localparam int TW = (UPDFC_PERIOD > 1) ? $clog2(UPDFC_PERIOD) : 1;
    logic [TW-1:0] tmr;
    assign tick = (state == INIT_FC_COMPLETE) && (tmr == TW'(UPDFC_PERIOD - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                tmr <= '0;
        else if (dl_status_i == DL_DOWN)           tmr <= '0;
        else if (state == INIT_FC_COMPLETE)        tmr <= tick ? '0 : tmr + 1'b1;
    end
`else
    assign tick = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT_FCDLE; fc_init_done_o <= 1'b0;
            m_dllp_tvalid <= 1'b0; m_dllp_tdata <= '0;
            fc1_seen <= 1'b0; fc2_seen <= 1'b0; ack_pend <= 1'b0; nak_pend <= 1'b0;
            seq <= '0; upd_pend <= '0; rr_ptr <= '0;
        end else if (dl_status_i == DL_DOWN) begin
            state <= INIT_FCDLE; fc_init_done_o <= 1'b0;
            m_dllp_tvalid <= 1'b0;
            fc1_seen <= 1'b0; fc2_seen <= 1'b0; ack_pend <= 1'b0; nak_pend <= 1'b0;
            upd_pend <= '0;
        end else begin
            if (state != INIT_FCDLE) begin
                fc1_seen <= fc1_seen | fc1_rx_i;
                fc2_seen <= fc2_seen | fc2_rx_i;
            end
            ack_pend <= ack_n;
            nak_pend <= nak_n;
            seq      <= seq_n;
            upd_pend <= upd_n;
            if (|take_upd) rr_ptr <= nxt(upd_sel);
            if (load_en) begin
                m_dllp_tvalid <= load_item;
                if (load_item) m_dllp_tdata <= item;
            end
            case (state)
                INIT_FCDLE:     state <= INIT_FC1_P;
                INIT_FC1_P:     if (load_en) state <= INIT_FC1_NP;
                INIT_FC1_NP:    if (load_en) state <= INIT_FC1_CPL;
                INIT_FC1_CPL:   if (load_en) state <= CHECK_FC1_VALS;
                CHECK_FC1_VALS: state <= fc1_seen ? INIT_FC2_P : INIT_FC1_P;
                INIT_FC2_P:     if (load_en) state <= INIT_FC2_NP;
                INIT_FC2_NP:    if (load_en) state <= INIT_FC2_CPL;
                INIT_FC2_CPL:   if (load_en) state <= CHECK_FC2_VALS;
                CHECK_FC2_VALS: begin
                    if (fc2_seen) begin
                        state          <= INIT_FC_COMPLETE;
                        fc_init_done_o <= 1'b1;
                    end else begin
                        state <= INIT_FC2_P;
                    end
                end
                INIT_FC_COMPLETE: ;
                default:        state <= INIT_FCDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcie_dllp_tx_scheduler.sv
// Bench for pcie_dllp_tx_scheduler: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the DLLP sequencing rules.
module tb_pcie_dllp_tx_scheduler;
    localparam int VC = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  dl = 2'd0;
    logic        fc1 = 1'b0, fc2 = 1'b0, ack = 1'b0, nak = 1'b0;
    logic [11:0] seqi = '0;
    logic [2:0]  upd = '0;
    logic [23:0] ch = '0;
    logic [35:0] cd = '0;
    logic        tready = 1'b0;
    logic [31:0] tdata;
    logic        tvalid;
    logic [3:0]  fcs;
    logic        done;

    always #5 clk = ~clk;

    pcie_dllp_tx_scheduler #(.UPDFC_PERIOD(16)) dut (
        .clk(clk), .rst_n(rst_n), .dl_status_i(dl), .fc1_rx_i(fc1), .fc2_rx_i(fc2),
        .ack_req_i(ack), .nak_req_i(nak), .ack_seq_i(seqi), .upd_req_i(upd),
        .cred_hdr_i(ch), .cred_data_i(cd), .m_dllp_tdata(tdata), .m_dllp_tvalid(tvalid),
        .m_dllp_tready(tready), .fc_state_o(fcs), .fc_init_done_o(done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase numbers: 0 idle, 1-3 InitFC1 P/NP/Cpl, 4 check1, 5-7 InitFC2, 8 check2, 9 complete.
    int          m_state;
    bit          m_valid, m_done, m_f1, m_f2, m_ack, m_nak;
    logic [31:0] m_data;
    logic [11:0] m_seq;
    bit   [2:0]  m_upd;
    int          m_ptr, m_tmr;
    int          hdr_par[3]  = '{1, 1, 1};
    int          data_par[3] = '{'h40, 'h10, 'h40};

    function automatic logic [31:0] fc_word(input int t, input int hdr, input int data);
        return 32'(t | VC) | 32'((hdr >> 2) << 8) | 32'((hdr & 3) << 22)
             | 32'(((data >> 8) & 15) << 16) | 32'((data & 255) << 24);
    endfunction

    function automatic logic [31:0] seq_word(input int t, input int s);
        return 32'(t) | 32'(((s >> 8) & 15) << 16) | 32'((s & 255) << 24);
    endfunction

    task automatic model_reset();
        m_state = 0; m_valid = 0; m_done = 0; m_data = '0;
        m_f1 = 0; m_f2 = 0; m_ack = 0; m_nak = 0; m_seq = '0; m_upd = '0;
        m_ptr = 0; m_tmr = 0;
    endtask

    task automatic model_step();
        bit ld, got, tick, old_nak;
        logic [31:0] body;
        int nxt, slot, tk_upd, old_state;
        ld = !m_valid || tready;
        got = 0; tick = 0; body = '0; tk_upd = -1;
        old_state = m_state; old_nak = m_nak; nxt = m_state;
        if (dl == 2'd0) begin
            m_state = 0; m_valid = 0; m_done = 0;
            m_f1 = 0; m_f2 = 0; m_ack = 0; m_nak = 0; m_upd = '0; m_tmr = 0;
            return;
        end
`ifdef DLLP_TX_UPDFC_TIMER_EN
        if (m_state == 9) begin
            if (m_tmr == 15) begin tick = 1; m_tmr = 0; end
            else m_tmr++;
        end
`endif
        if (m_state == 0) nxt = 1;
        else if (m_state == 4) nxt = m_f1 ? 5 : 1;
        else if (m_state == 8) nxt = m_f2 ? 9 : 5;
        else if (m_state == 9) begin
            if (ld) begin
                if (m_nak) begin
                    got = 1; body = seq_word('h10, int'(m_seq)); m_nak = 0;
                end else if (m_ack) begin
                    got = 1; body = seq_word('h00, int'(m_seq)); m_ack = 0;
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        int t;
                        t = (m_ptr + k) % 3;
                        if (tk_upd < 0 && m_upd[t]) tk_upd = t;
                    end
                    if (tk_upd >= 0) begin
                        got = 1;
                        body = fc_word('h80 + 16 * tk_upd, int'(ch[8*tk_upd +: 8]), int'(cd[12*tk_upd +: 12]));
                        m_upd[tk_upd] = 1'b0;
                        m_ptr = (tk_upd + 1) % 3;
                    end
                end
            end
        end else if (ld) begin
            slot = (m_state - 1) % 4;
            got  = 1;
            body = fc_word(((m_state < 4) ? 'h40 : 'hC0) + 16 * slot, hdr_par[slot], data_par[slot]);
            nxt  = m_state + 1;
        end
        if (old_state != 0) begin
            m_f1 = m_f1 | fc1;
            m_f2 = m_f2 | fc2;
        end
        if (nak) begin
            m_nak = 1; m_ack = 0; m_seq = seqi;
        end else if (ack) begin
            m_seq = seqi;
            if (!old_nak) m_ack = 1;
        end
        m_upd = m_upd | upd | (tick ? 3'b111 : 3'b000);
        if (ld) begin
            m_valid = got;
            if (got) m_data = body;
        end
        m_state = nxt;
        m_done  = (m_state == 9);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Single compare point, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("tvalid", 32'(tvalid), 32'(m_valid));
            check("fc_state", 32'(fcs), 32'(m_state));
            check("init_done", 32'(done), 32'(m_done));
            if (m_valid) check("tdata", tdata, m_data);
            if (tvalid && tready) got_q.push_back(tdata);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_log(input int n, input int budget);
        int c = 0;
        while (got_q.size() < n && c < budget) begin step(1); c++; end
        if (got_q.size() < n) check("wait_log_timeout", 32'(got_q.size()), 32'(n));
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!done && c < budget) begin step(1); c++; end
        check("wait_done", 32'(done), 32'd1);
    endtask

    task automatic finish_init();
        fc1 = 1; step(1); fc1 = 0;
        fc2 = 1; step(1); fc2 = 0;
        wait_done(60);
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, got_q[i], exp_q[i]);
    endtask

    initial begin
        int n_bad_type;
        logic [7:0] fc1_types[3];
        step(3);
        check("reset_tvalid", 32'(tvalid), 32'd0);
        check("reset_tdata", tdata, 32'd0);
        check("reset_state", 32'(fcs), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Full init handshake with the partner answering promptly.
        tready = 1; dl = 2'd1; got_q.delete();
        wait_log(1, 20);
        fc1 = 1; step(1); fc1 = 0;
        fc2 = 1; step(1); fc2 = 0;
        wait_done(40);
        step(2);
        exp_q = '{32'h4040_0040, 32'h1040_0050, 32'h4040_0060,
                  32'h4040_00C0, 32'h1040_00D0, 32'h4040_00E0};
        check_log("init_seq");
        check("complete_state", 32'(fcs), 32'd9);

        // Idle in COMPLETE.
        got_q.delete();
        step(40);
`ifdef DLLP_TX_UPDFC_TIMER_EN
        check("timer_updfc", 32'(got_q.size() >= 6), 32'd1);
`else
        check("idle_quiet", 32'(got_q.size()), 32'd0);
`endif

        // UpdateFC triplet; credits sampled at load time.
        ch = {8'h33, 8'h22, 8'hFF};
        cd = {12'h777, 12'h555, 12'hABC};
        got_q.delete();
        upd = 3'b111; step(1); upd = 3'b000;
        wait_log(3, 20);
        step(2);
        exp_q = '{32'hBCCA_3F80, 32'h5585_0890, 32'h77C7_0CA0};
        check_log("updfc_seq");

        // Stalled output: Ack then Nak collapse into one Nak behind the held DLLP.
        tready = 0; got_q.delete();
        upd = 3'b100; step(1); upd = 3'b000;
        ack = 1; seqi = 12'h123; step(1); ack = 0;
        nak = 1; seqi = 12'h456; step(1); nak = 0;
        step(3);
        check("stall_held", tdata, 32'h77C7_0CA0);
        tready = 1;
        wait_log(2, 20);
        step(3);
        exp_q = '{32'h77C7_0CA0, 32'h5604_0010};
        check_log("nak_wins");

        // Partner never answers InitFC1: only InitFC1 triplets.
        dl = 2'd0; step(2);
        check("down_state", 32'(fcs), 32'd0);
        check("down_tvalid", 32'(tvalid), 32'd0);
        dl = 2'd1; got_q.delete();
        step(40);
        fc1_types = '{8'h40, 8'h50, 8'h60};
        n_bad_type = 0;
        foreach (got_q[i]) if (got_q[i][7:0] != fc1_types[i % 3]) n_bad_type++;
        check("nofc1_only_fc1", 32'(n_bad_type), 32'd0);
        check("nofc1_repeats", 32'(got_q.size() >= 9), 32'd1);
        finish_init();

        // DL_DOWN mid-triplet with a stalled DLLP and a pending Ack.
        dl = 2'd0; step(1); dl = 2'd1; tready = 0;
        step(3);
        check("stalled_before_down", 32'(tvalid), 32'd1);
        ack = 1; seqi = 12'h077; step(1); ack = 0;
        step(2);
        dl = 2'd0; step(1);
        check("down_drop_tvalid", 32'(tvalid), 32'd0);
        check("down_drop_state", 32'(fcs), 32'd0);
        dl = 2'd1; tready = 1; got_q.delete();
        step(2);
        finish_init();
        step(10);
        n_bad_type = 0;
        foreach (got_q[i]) if (got_q[i][7:0] == 8'h00 || got_q[i][7:0] == 8'h10) n_bad_type++;
        check("ack_discarded", 32'(n_bad_type), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            dl     = ($urandom_range(0, 249) == 0) ? 2'd0 : 2'($urandom_range(1, 2));
            fc1    = ($urandom_range(0, 7) == 0);
            fc2    = ($urandom_range(0, 7) == 0);
            ack    = ($urandom_range(0, 9) == 0);
            nak    = ($urandom_range(0, 19) == 0);
            seqi   = 12'($urandom);
            upd    = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            ch     = 24'($urandom);
            cd     = {4'($urandom), 32'($urandom)};
            tready = ($urandom_range(0, 9) < 7);
            step(1);
        end
        dl = 2'd1; fc1 = 0; fc2 = 0; ack = 0; nak = 0; upd = 0; tready = 1;
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
